// File: rtl/phy_tx_64b66b.sv
// Transmit-side 64B/66B PCS encoder: AXI-Stream frames -> GT txdata/txheader/txsequence
// for a lane in external-sequence gearbox mode. Scrambling happens downstream.
module phy_tx_64b66b #(
  parameter int unsigned SEQ_MAX = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_data,
  input  logic [7:0]  s_axis_keep,
  input  logic        s_axis_last,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic [63:0] o_gt0_txdata,
  output logic [1:0]  o_gt0_txheader,
  output logic [6:0]  o_gt0_txsequence
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TAIL,
    S_GAP
  } state_t;

  localparam logic [63:0] IDLE_BLK = 64'h1E00_0000_0000_0000;
  localparam logic [1:0]  HDR_DATA = 2'b01;
  localparam logic [1:0]  HDR_CTRL = 2'b10;
  localparam logic [6:0]  SEQ_LAST = 7'(SEQ_MAX);
  localparam logic [6:0]  SEQ_HOLD = 7'(SEQ_MAX - 1);

  state_t      r_state;
  logic [6:0]  r_seq;
  logic [63:0] r_txdata;
  logic [1:0]  r_txheader;
  logic [7:0]  r_carry;
  logic        r_tail_carry;

  state_t      w_state_nxt;
  logic [63:0] w_data_nxt;
  logic [1:0]  w_hdr_nxt;
  logic [7:0]  w_carry_nxt;
  logic        w_tail_carry_nxt;
  logic        w_advance;
  logic        w_accept;
  logic [7:0]  w_keep_eff;
  logic [63:0] w_beat;
  logic [3:0]  w_k;

  // Number of leading ones in a last-beat keep mask (bytes actually present).
  function automatic logic [3:0] lead_ones(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (run && keep[i]) n = n + 4'd1;
      else                run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [7:0] term_type(input logic [3:0] n);
    case (n)
      4'd0:    return 8'h87;
      4'd1:    return 8'h99;
      4'd2:    return 8'hAA;
      4'd3:    return 8'hB4;
      4'd4:    return 8'hCC;
      4'd5:    return 8'hD2;
      4'd6:    return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  // The GT ignores the word shown at SEQ_MAX, so nothing moves on the edge into it.
  assign w_advance    = (r_seq != SEQ_HOLD);
  assign s_axis_ready = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_advance && !i_rst;
  assign w_accept     = s_axis_valid && s_axis_ready;
  assign w_keep_eff   = s_axis_last ? s_axis_keep : 8'hFF;
  assign w_k          = lead_ones(s_axis_keep);

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < 8; i++) begin
      w_beat[63-8*i -: 8] = s_axis_data[63-8*i -: 8] & {8{w_keep_eff[7-i]}};
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_nxt       = IDLE_BLK;
    w_hdr_nxt        = HDR_CTRL;
    w_carry_nxt      = r_carry;
    w_tail_carry_nxt = r_tail_carry;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_data_nxt       = {8'h78, w_beat[63:8]};
          w_carry_nxt      = w_beat[7:0];
          w_tail_carry_nxt = 1'b1;
          w_state_nxt      = s_axis_last ? S_TAIL : S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (!s_axis_last || w_k >= 4'd7) begin
            w_data_nxt  = {r_carry, w_beat[63:8]};
            w_hdr_nxt   = HDR_DATA;
            w_carry_nxt = w_beat[7:0];
            // A 7-byte tail leaves nothing to carry: close with an empty T0.
            if (s_axis_last) begin
              w_tail_carry_nxt = (w_k == 4'd8);
              w_state_nxt      = S_TAIL;
            end
          end else begin
            w_data_nxt  = {term_type(w_k + 4'd1), r_carry, w_beat[63:16]};
            w_state_nxt = S_GAP;
          end
        end
      end
      S_TAIL: begin
        w_data_nxt  = r_tail_carry ? {8'h99, r_carry, 48'h0} : {8'h87, 56'h0};
        w_state_nxt = S_GAP;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seq        <= '0;
      r_state      <= S_IDLE;
      r_txdata     <= IDLE_BLK;
      r_txheader   <= HDR_CTRL;
      r_carry      <= '0;
      r_tail_carry <= 1'b0;
    end else begin
      r_seq <= (r_seq == SEQ_LAST) ? 7'd0 : r_seq + 7'd1;
      if (w_advance) begin
        r_state      <= w_state_nxt;
        r_txdata     <= w_data_nxt;
        r_txheader   <= w_hdr_nxt;
        r_carry      <= w_carry_nxt;
        r_tail_carry <= w_tail_carry_nxt;
      end
    end
  end

  assign o_gt0_txdata     = r_txdata;
  assign o_gt0_txheader   = r_txheader;
  assign o_gt0_txsequence = r_seq;

endmodule

// File: tb/tb_phy_tx_64b66b.sv
// Scoreboard bench for phy_tx_64b66b: directed frames, gearbox pause, async reset.
module tb_phy_tx_64b66b;

  localparam logic [63:0] IDLE_BLK = 64'h1E00_0000_0000_0000;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
  } blk_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] s_axis_data = '0;
  logic [7:0]  s_axis_keep = '0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic [63:0] o_gt0_txdata;
  logic [1:0]  o_gt0_txheader;
  logic [6:0]  o_gt0_txsequence;

  int   n_cmp = 0;
  int   n_bad = 0;
  blk_t exp_q[$];
  logic after_term = 1'b0;

  phy_tx_64b66b #(.SEQ_MAX(32)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .s_axis_data      (s_axis_data),
    .s_axis_keep      (s_axis_keep),
    .s_axis_last      (s_axis_last),
    .s_axis_valid     (s_axis_valid),
    .s_axis_ready     (s_axis_ready),
    .o_gt0_txdata     (o_gt0_txdata),
    .o_gt0_txheader   (o_gt0_txheader),
    .o_gt0_txsequence (o_gt0_txsequence)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] h);
    blk_t b;
    b.d = d;
    b.h = h;
    exp_q.push_back(b);
  endtask

  // Monitor: every word the GT consumes (txsequence != 32); idles only checked right after a terminate.
  always @(negedge i_clk) begin
    blk_t e;
    if (i_rst) begin
      after_term = 1'b0;
    end else if (o_gt0_txsequence != 7'd32) begin
      if (after_term || !(o_gt0_txheader == 2'b10 && o_gt0_txdata == IDLE_BLK)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_block", {o_gt0_txheader, o_gt0_txdata[61:0]}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("blk_data", o_gt0_txdata, e.d);
          check("blk_hdr", 64'(o_gt0_txheader), 64'(e.h));
        end
        after_term = (o_gt0_txheader == 2'b10) && (o_gt0_txdata[63:56] != 8'h1E)
                     && (o_gt0_txdata[63:56] != 8'h78);
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit done;
    s_axis_data  = d;
    s_axis_keep  = k;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge i_clk);
      if (s_axis_ready) begin
        @(posedge i_clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_seq(input logic [6:0] v);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge i_clk);
      #1;
      hit = (o_gt0_txsequence == v);
    end
    if (!hit) check("seq_timeout", 64'(o_gt0_txsequence), 64'(v));
  endtask

  // Four full beats 0x11..0x44 then a last beat of 0x55 bytes with the given keep.
  task automatic send_frame(input logic [7:0] last_keep);
    send_beat({8{8'h11}}, 8'hFF, 1'b0);
    send_beat({8{8'h22}}, 8'hFF, 1'b0);
    send_beat({8{8'h33}}, 8'hFF, 1'b0);
    send_beat({8{8'h44}}, 8'hFF, 1'b0);
    send_beat({8{8'h55}}, last_keep, 1'b1);
  endtask

  task automatic push_head;
    push(64'h7811111111111111, 2'b10);
    push(64'h1122222222222222, 2'b01);
    push(64'h2233333333333333, 2'b01);
    push(64'h3344444444444444, 2'b01);
  endtask

  initial begin
    logic [6:0] exp_seq;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_data", o_gt0_txdata, IDLE_BLK);
    check("rst_hdr", 64'(o_gt0_txheader), 64'h2);
    check("rst_ready", 64'(s_axis_ready), 64'h0);
    check("rst_seq", 64'(o_gt0_txsequence), 64'h0);
    i_rst = 1'b0;
    #1;
    exp_seq = 7'd0;
    check("idle_seq0", 64'(o_gt0_txsequence), 64'(exp_seq));
    check("idle_ready0", 64'(s_axis_ready), 64'h1);
    for (int c = 0; c < 36; c++) begin
      @(posedge i_clk);
      #1;
      exp_seq = (exp_seq == 7'd32) ? 7'd0 : exp_seq + 7'd1;
      check("idle_seq", 64'(o_gt0_txsequence), 64'(exp_seq));
      check("idle_ready", 64'(s_axis_ready), 64'(exp_seq != 7'd31));
    end
    check("idle_data", o_gt0_txdata, IDLE_BLK);
    check("idle_hdr", 64'(o_gt0_txheader), 64'h2);

    // Frame with a 2-byte tail -> T3
    wait_seq(7'd0);
    push_head();
    push(64'hB444555500000000, 2'b10);
    push(IDLE_BLK, 2'b10);
    send_frame(8'hC0);
    check("c0_ready_gap", 64'(s_axis_ready), 64'h0);
    @(posedge i_clk); #1;
    check("c0_ready_back", 64'(s_axis_ready), 64'h1);

    // Frame with a 1-byte tail -> T2
    wait_seq(7'd0);
    push_head();
    push(64'hAA44550000000000, 2'b10);
    push(IDLE_BLK, 2'b10);
    send_frame(8'h80);
    check("80_ready_gap", 64'(s_axis_ready), 64'h0);
    @(posedge i_clk); #1;
    check("80_ready_back", 64'(s_axis_ready), 64'h1);

    // Full last beat -> data block, then T1 with the carried byte
    wait_seq(7'd0);
    push_head();
    push(64'h4455555555555555, 2'b01);
    push(64'h9955000000000000, 2'b10);
    push(IDLE_BLK, 2'b10);
    send_frame(8'hFF);
    check("ff_ready_tail", 64'(s_axis_ready), 64'h0);
    @(posedge i_clk); #1;
    check("ff_ready_gap", 64'(s_axis_ready), 64'h0);
    @(posedge i_clk); #1;
    check("ff_ready_back", 64'(s_axis_ready), 64'h1);

    // Frame straddling the gearbox pause at txsequence 31/32
    wait_seq(7'd28);
    push_head();
    push(64'hB444555500000000, 2'b10);
    push(IDLE_BLK, 2'b10);
    fork
      send_frame(8'hC0);
      begin
        wait_seq(7'd31);
        check("pause_ready31", 64'(s_axis_ready), 64'h0);
        check("pause_data31", o_gt0_txdata, 64'h2233333333333333);
        @(posedge i_clk); #1;
        check("pause_seq32", 64'(o_gt0_txsequence), 64'd32);
        check("pause_data32", o_gt0_txdata, 64'h2233333333333333);
        check("pause_hdr32", 64'(o_gt0_txheader), 64'h1);
      end
    join

    // Async reset in the middle of a frame
    wait_seq(7'd5);
    push(64'h7811111111111111, 2'b10);
    push(64'h1122222222222222, 2'b01);
    send_beat({8{8'h11}}, 8'hFF, 1'b0);
    send_beat({8{8'h22}}, 8'hFF, 1'b0);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_data", o_gt0_txdata, IDLE_BLK);
    check("mid_rst_hdr", 64'(o_gt0_txheader), 64'h2);
    check("mid_rst_ready", 64'(s_axis_ready), 64'h0);
    check("mid_rst_seq", 64'(o_gt0_txsequence), 64'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_seq(7'd2);
    push_head();
    push(64'hB444555500000000, 2'b10);
    push(IDLE_BLK, 2'b10);
    send_frame(8'hC0);

    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
